// File: rtl/can_rx_crc_check.sv
// Receive-side CAN CRC-15 checker: runs the LFSR over SOF..data plus the received CRC field
// and checks the delimiter. Optional debug ports are enabled with CAN_RX_CRC_DEBUG_EN.
module can_rx_crc_check #(
  parameter int               CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY  = 15'h4599,
  parameter logic [CRC_W-1:0] INIT  = 15'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sof,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_val,
  input  logic             crc_field,
`ifdef CAN_RX_CRC_DEBUG_EN
  output logic [CRC_W-1:0] calc_crc,
  output logic [CRC_W-1:0] crc_mismatch_bits,
`endif
  output logic             busy,
  output logic             crc_done,
  output logic             crc_err,
  output logic             delim_err,
  output logic [CRC_W-1:0] rx_crc
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_CRC_RX = 2'd2;
  localparam logic [1:0] ST_DELIM  = 2'd3;

  localparam logic [3:0] LAST_CNT  = 4'd14;

  // One CAN CRC-15 LFSR step, bit-exact with the TX generator.
  function automatic logic [CRC_W-1:0] lfsr_step(input logic [CRC_W-1:0] s, input logic b);
    logic inv;
    inv = b ^ s[CRC_W-1];
    return {s[CRC_W-2:0], 1'b0} ^ (inv ? POLY : {CRC_W{1'b0}});
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CRC_W-1:0] rx_crc_q, rx_crc_d;
  logic             crc_err_q, crc_err_d;
  logic             delim_err_q, delim_err_d;
  logic             crc_done_q, crc_done_d;
  logic             busy_q;
`ifdef CAN_RX_CRC_DEBUG_EN
  logic [CRC_W-1:0] calc_q, calc_d;
  logic [CRC_W-1:0] mism_q, mism_d;
`endif

  // Next-state logic; abort outranks sof, which outranks bit_valid.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    rx_crc_d    = rx_crc_q;
    crc_err_d   = crc_err_q;
    delim_err_d = delim_err_q;
    crc_done_d  = 1'b0;
`ifdef CAN_RX_CRC_DEBUG_EN
    calc_d      = calc_q;
    mism_d      = mism_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else if (sof) begin
      state_d     = ST_ACCUM;
      lfsr_d      = INIT;
      cnt_d       = 4'd0;
      rx_crc_d    = {CRC_W{1'b0}};
      crc_err_d   = 1'b0;
      delim_err_d = 1'b0;
`ifdef CAN_RX_CRC_DEBUG_EN
      calc_d      = {CRC_W{1'b0}};
      mism_d      = {CRC_W{1'b0}};
`endif
    end else if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACCUM: begin
          lfsr_d = lfsr_step(lfsr_q, bit_val);
          if (crc_field) begin
            rx_crc_d = {rx_crc_q[CRC_W-2:0], bit_val};
            cnt_d    = 4'd1;
            state_d  = ST_CRC_RX;
`ifdef CAN_RX_CRC_DEBUG_EN
            calc_d   = lfsr_q;
`endif
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_CRC_RX: begin
          // The counter alone ends the field; crc_field is not looked at here.
          lfsr_d   = lfsr_step(lfsr_q, bit_val);
          rx_crc_d = {rx_crc_q[CRC_W-2:0], bit_val};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DELIM;
          end else begin
            state_d = ST_CRC_RX;
          end
        end
        ST_DELIM: begin
          delim_err_d = ~bit_val;
          crc_err_d   = (lfsr_q != {CRC_W{1'b0}});
          crc_done_d  = 1'b1;
          state_d     = ST_IDLE;
`ifdef CAN_RX_CRC_DEBUG_EN
          mism_d      = calc_q ^ rx_crc_q;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= INIT;
      cnt_q       <= 4'd0;
      rx_crc_q    <= {CRC_W{1'b0}};
      crc_err_q   <= 1'b0;
      delim_err_q <= 1'b0;
      crc_done_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CAN_RX_CRC_DEBUG_EN
      calc_q      <= {CRC_W{1'b0}};
      mism_q      <= {CRC_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      rx_crc_q    <= rx_crc_d;
      crc_err_q   <= crc_err_d;
      delim_err_q <= delim_err_d;
      crc_done_q  <= crc_done_d;
      busy_q      <= (state_d != ST_IDLE);
`ifdef CAN_RX_CRC_DEBUG_EN
      calc_q      <= calc_d;
      mism_q      <= mism_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign crc_done  = crc_done_q;
  assign crc_err   = crc_err_q;
  assign delim_err = delim_err_q;
  assign rx_crc    = rx_crc_q;
`ifdef CAN_RX_CRC_DEBUG_EN
  assign calc_crc          = calc_q;
  assign crc_mismatch_bits = mism_q;
`endif

endmodule

// File: doc/can_rx_crc_check.md
Name: can_rx_crc_check

Overview:
- Receive-side CRC-15 checker for the CAN MAC.
- Consumes the destuffed bit stream from the RX bit-timing/destuff stage, under field qualification from the MAC RX FSM.
- Runs the CAN CRC-15 LFSR over SOF..data and then over the received 15-bit CRC field; a zero remainder means the CRC is good.
- Also checks the CRC delimiter and reports one result per frame to the MAC RX FSM and the error-management logic.

Parameters:
- CRC_W, 15, CRC width. The checker is specified for 15 only.
- POLY, 15'h4599, feedback taps x^15+x^14+x^10+x^8+x^7+x^4+x^3+1.
- INIT, 15'h0000, LFSR value loaded on sof.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active low
- sof  in  1  one-cycle pulse: a new frame starts; clears the LFSR and enters ACCUM
- abort  in  1  one-cycle pulse: the frame is abandoned (error frame or arbitration loss); returns to IDLE with no result
- bit_valid  in  1  one-cycle strobe, one per destuffed bit
- bit_val  in  1  bit value (1 = recessive)
- crc_field  in  1  level: the current bit_valid belongs to the CRC field
- busy  out  1  high in any state other than IDLE
- crc_done  out  1  one-cycle pulse: the result is valid
- crc_err  out  1  remainder was non-zero; held until the next sof
- delim_err  out  1  CRC delimiter was dominant; held until the next sof
- rx_crc  out  15  received CRC field, MSB first into bit 0 shifting left; held until the next sof

Behaviour:
- Reset values: all outputs 0, LFSR = INIT, bit counter = 0, state IDLE.
- LFSR step, applied on every bit_valid in ACCUM or CRC_RX:
  - inv = bit_val ^ lfsr[14]
  - lfsr = {lfsr[13:0],1'b0} ^ (inv ? POLY : 0)
  - This is bit-exact with the TX CRC generator.
- IDLE:
  - bit_valid is ignored.
  - sof -> ACCUM; on entry LFSR = INIT, cnt = 0, rx_crc = 0, crc_err = 0, delim_err = 0.
- ACCUM, on bit_valid & !crc_field:
  - LFSR step.
- ACCUM, on bit_valid & crc_field:
  - LFSR step.
  - rx_crc = {rx_crc[13:0], bit_val}.
  - cnt = 1.
  - Go to CRC_RX.
- CRC_RX, on each bit_valid:
  - LFSR step, rx_crc shift, cnt++.
  - When the bit just taken makes cnt = 15, go to DELIM.
  - crc_field is not examined in CRC_RX; the counter alone ends the field.
- DELIM, on the next bit_valid:
  - No LFSR step.
  - delim_err = !bit_val.
  - crc_err = (lfsr != 0).
  - crc_done pulses in the following cycle.
  - Go to IDLE.
- Latency: crc_done is high exactly 1 clk after the clock edge that samples the delimiter bit_valid. crc_err and delim_err are valid in that same cycle and stay stable afterwards.
- Priority, highest first: rst_n, abort, sof, bit_valid.
  - abort together with sof: go to IDLE.
  - sof together with bit_valid: restart; the bit is discarded.
  - sof in any non-IDLE state restarts the frame silently, with no crc_done.
- abort in any state: go to IDLE, no crc_done. crc_err, delim_err and rx_crc keep their prior values.
- Back-to-back frames: sof in the same cycle as crc_done is legal. crc_done still pulses, and the flags clear on the next edge.
- Asynchronous reset mid-frame: everything returns to reset values immediately; no pulse is produced.

Optional Feature:
- Macro: CAN_RX_CRC_DEBUG_EN.
- Defined:
  - Extra output calc_crc[14:0] = LFSR snapshot captured on the first CRC-field bit, before that bit's step. This is the CRC computed over the frame body.
  - Extra output crc_mismatch_bits[14:0] = calc_crc ^ rx_crc, valid with crc_done.
  - Both ports are reset to 0 and held until the next sof.
- Undefined:
  - Neither port exists and no snapshot register is built.
  - All other behaviour is identical.

Test Plan:
- sof; data bits "1"; CRC field 0x4599 MSB first; delimiter 1 -> crc_done 1 clk after the delimiter strobe, crc_err=0, delim_err=0, rx_crc=15'h4599. Debug build: calc_crc=15'h4599.
- sof; data "0"; CRC 0x0000; delimiter 0 -> crc_err=0, delim_err=1.
- sof; data "1"; CRC 0x4598 (LSB flipped); delimiter 1 -> crc_err=1, delim_err=0. Debug build: crc_mismatch_bits=15'h0001.
- sof; data "1"; 7 CRC bits; abort -> busy=0 next cycle, no crc_done. Then a full good frame -> crc_err=0.
- sof asserted with bit_valid, bit_val=1, then data "0" and CRC 0x0000 -> the first bit is discarded and crc_err=0. Separately, sof during CRC_RX -> restart with no crc_done.
- rst_n pulled low mid-CRC_RX -> all outputs 0 asynchronously; bit_valid after reset release is ignored until sof.
